jelly_rtos_task_tmo: RTL and testbench

//  Per-task control block (TCB) for the hardware RTOS scheduler. Holds one task's state,

---
 rtl/jelly_rtos_task_tmo.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_jelly_rtos_task_tmo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_rtos_task_tmo.sv
// Per-task control block: state, wait cause, nest counters, priority,
// timed waits with return code, and ready-queue add/remove requests.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cke_i                 clock enable (all state holds when 0)
//   busy_o                mirrors rdq_add_o
//   tskstat_o             RUN=1 RDY=2 WAI=4 SUS=8 WAS=C
//   tskwait_o             {FLG,SEM,SLP,DLY} wait cause, one-hot or 0
//   wairet_o              0 E_OK, 1 E_TMOUT, 2 E_RLWAI
//   wupcnt_o, suscnt_o    wakeup / suspend nest counters
//   tskpri_o              current priority
//   rdq_add_o             registered ready-queue insert request
//   rdq_rmv_o             combinational ready-queue remove strobe
//   rdy_tsk_i             insert acknowledge
//   rel_tsk_i             semaphore releases this task
//   flgptn_i              current event-flag pattern
//   run_tskid_i           running task id
//   op_tskid_i            target task id of the op strobes
//   *_tsk_i / *_i strobes wup slp sus rsm dly rel_wai wai_sem wai_flg chg_pri
//   op_tmout_i            timeout / delay (all-ones = wait forever)
//   op_tskpri_i           new priority for chg_pri
//   wai_flg_wfmode_i      0 AND, 1 OR
//   wai_flg_flgptn_i      wait pattern for wai_flg
module jelly_rtos_task_tmo #(
    parameter int TSKID_WIDTH  = 4,
    parameter int TSKPRI_WIDTH = 4,
    parameter int FLGPTN_WIDTH = 4,
    parameter int RELTIM_WIDTH = 32,
    parameter int WUPCNT_WIDTH = 1,
    parameter int SUSCNT_WIDTH = 1,
    parameter int TSKID        = 0,
    parameter int INIT_TSKPRI  = TSKID,
    parameter logic [WUPCNT_WIDTH-1:0] TMAX_WUPCNT = '1,
    parameter logic [SUSCNT_WIDTH-1:0] TMAX_SUSCNT = '1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cke_i,
    output logic                    busy_o,
    output logic [3:0]              tskstat_o,
    output logic [3:0]              tskwait_o,
    output logic [1:0]              wairet_o,
    output logic [WUPCNT_WIDTH-1:0] wupcnt_o,
    output logic [SUSCNT_WIDTH-1:0] suscnt_o,
    output logic [TSKPRI_WIDTH-1:0] tskpri_o,
    output logic                    rdq_add_o,
    output logic                    rdq_rmv_o,
    input  logic                    rdy_tsk_i,
    input  logic                    rel_tsk_i,
    input  logic [FLGPTN_WIDTH-1:0] flgptn_i,
    input  logic [TSKID_WIDTH-1:0]  run_tskid_i,
    input  logic [TSKID_WIDTH-1:0]  op_tskid_i,
    input  logic                    wup_tsk_i,
    input  logic                    slp_tsk_i,
    input  logic                    sus_tsk_i,
    input  logic                    rsm_tsk_i,
    input  logic                    dly_tsk_i,
    input  logic                    rel_wai_i,
    input  logic                    wai_sem_i,
    input  logic                    wai_flg_i,
    input  logic                    chg_pri_i,
    input  logic [RELTIM_WIDTH-1:0] op_tmout_i,
    input  logic [TSKPRI_WIDTH-1:0] op_tskpri_i,
    input  logic                    wai_flg_wfmode_i,
    input  logic [FLGPTN_WIDTH-1:0] wai_flg_flgptn_i
);

    localparam logic [3:0] W_DLY = 4'b0001;
    localparam logic [3:0] W_SLP = 4'b0010;
    localparam logic [3:0] W_SEM = 4'b0100;
    localparam logic [3:0] W_FLG = 4'b1000;

    localparam logic [1:0] E_OK    = 2'd0;
    localparam logic [1:0] E_TMOUT = 2'd1;
    localparam logic [1:0] E_RLWAI = 2'd2;

    localparam logic [TSKID_WIDTH-1:0]  MY_ID    = TSKID_WIDTH'(TSKID);
    localparam logic [TSKPRI_WIDTH-1:0] INIT_PRI = TSKPRI_WIDTH'(INIT_TSKPRI);

    logic                    wai_q, wai_d;
    logic                    sus_q, sus_d;
    logic [3:0]              tskwait_q, tskwait_d;
    logic [1:0]              wairet_q, wairet_d;
    logic [WUPCNT_WIDTH-1:0] wupcnt_q, wupcnt_d;
    logic [SUSCNT_WIDTH-1:0] suscnt_q, suscnt_d;
    logic [TSKPRI_WIDTH-1:0] tskpri_q, tskpri_d;
    logic                    rdq_add_q, rdq_add_d;
    logic                    tim_arm_q, tim_arm_d;
    logic [RELTIM_WIDTH-1:0] timcnt_q, timcnt_d;
    logic                    fmode_q, fmode_d;
    logic [FLGPTN_WIDTH-1:0] fptn_q, fptn_d;

    logic                    my_op, my_run, ready;
    logic                    flg_hit;
    logic                    rel, add_req, rmv;
    logic [1:0]              ret;
    logic                    enter;
    logic [3:0]              cause;

    assign my_op  = (op_tskid_i == MY_ID);
    assign my_run = (run_tskid_i == MY_ID);
    assign ready  = !wai_q && !sus_q;

    // OR mode: any bit in common; AND mode: every pattern bit present.
    assign flg_hit = fmode_q ? |(flgptn_i & fptn_q)
                             : ((flgptn_i & fptn_q) == fptn_q);

    always_comb begin
        wai_d     = wai_q;
        sus_d     = sus_q;
        tskwait_d = tskwait_q;
        wairet_d  = wairet_q;
        wupcnt_d  = wupcnt_q;
        suscnt_d  = suscnt_q;
        tskpri_d  = tskpri_q;
        rdq_add_d = rdq_add_q;
        tim_arm_d = tim_arm_q;
        timcnt_d  = timcnt_q;
        fmode_d   = fmode_q;
        fptn_d    = fptn_q;
        rel       = 1'b0;
        ret       = E_OK;
        add_req   = 1'b0;
        rmv       = 1'b0;
        enter     = 1'b0;
        cause     = 4'b0000;

        if (cke_i) begin
            if (tim_arm_q && timcnt_q != '0) begin
                timcnt_d = timcnt_q - RELTIM_WIDTH'(1);
            end

            // Release sources, highest priority first; only one is taken.
            if (wai_q) begin
                if (rel_wai_i && my_op) begin
                    rel = 1'b1;
                    ret = E_RLWAI;
                end else if (rel_tsk_i && tskwait_q == W_SEM) begin
                    rel = 1'b1;
                end else if (wup_tsk_i && my_op && tskwait_q == W_SLP) begin
                    rel = 1'b1;
                end else if (tskwait_q == W_FLG && flg_hit) begin
                    rel = 1'b1;
                end else if (tim_arm_q && timcnt_q == '0) begin
                    rel = 1'b1;
                    ret = (tskwait_q == W_DLY) ? E_OK : E_TMOUT;
                end
            end

            if (wup_tsk_i && my_op && !(wai_q && tskwait_q == W_SLP)) begin
                if (wupcnt_q != TMAX_WUPCNT) begin
                    wupcnt_d = wupcnt_q + WUPCNT_WIDTH'(1);
                end
            end

            if (slp_tsk_i && my_op && !wai_q) begin
                if (wupcnt_q != '0) begin
                    wupcnt_d = wupcnt_q - WUPCNT_WIDTH'(1);
                end else begin
                    enter = 1'b1;
                    cause = W_SLP;
                end
            end

            if (dly_tsk_i && my_op && !wai_q) begin
                enter = 1'b1;
                cause = W_DLY;
            end

            if (wai_sem_i && my_run && !wai_q) begin
                enter = 1'b1;
                cause = W_SEM;
            end

            if (wai_flg_i && my_run && !wai_q) begin
                enter   = 1'b1;
                cause   = W_FLG;
                fmode_d = wai_flg_wfmode_i;
                fptn_d  = wai_flg_flgptn_i;
            end

            if (enter) begin
                wai_d     = 1'b1;
                tskwait_d = cause;
                wairet_d  = E_OK;
                rmv       = 1'b1;
                timcnt_d  = op_tmout_i;
                tim_arm_d = (op_tmout_i != '1);
            end

            if (sus_tsk_i && my_op) begin
                sus_d = 1'b1;
                rmv   = rmv | ready;
                if (suscnt_q != TMAX_SUSCNT) begin
                    suscnt_d = suscnt_q + SUSCNT_WIDTH'(1);
                end
            end

            if (rsm_tsk_i && my_op && suscnt_q != '0) begin
                suscnt_d = suscnt_q - SUSCNT_WIDTH'(1);
                if (suscnt_q == SUSCNT_WIDTH'(1)) begin
                    sus_d   = 1'b0;
                    add_req = !wai_q;
                end
            end

            if (chg_pri_i && my_op) begin
                tskpri_d = op_tskpri_i;
                if (ready) begin
                    rmv     = 1'b1;
                    add_req = 1'b1;
                end
            end

            if (rel) begin
                wai_d     = 1'b0;
                tskwait_d = 4'b0000;
                tim_arm_d = 1'b0;
                wairet_d  = ret;
                if (!sus_d) begin
                    add_req = 1'b1;
                end
            end

            // A fresh request overrides a same-cycle acknowledge.
            rdq_add_d = (rdq_add_q && !rdy_tsk_i) || add_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wai_q     <= 1'b1;
            sus_q     <= 1'b0;
            tskwait_q <= W_SLP;
            wairet_q  <= E_OK;
            wupcnt_q  <= '0;
            suscnt_q  <= '0;
            tskpri_q  <= INIT_PRI;
            rdq_add_q <= 1'b0;
            tim_arm_q <= 1'b0;
            timcnt_q  <= '0;
            fmode_q   <= 1'b0;
            fptn_q    <= '0;
        end else begin
            wai_q     <= wai_d;
            sus_q     <= sus_d;
            tskwait_q <= tskwait_d;
            wairet_q  <= wairet_d;
            wupcnt_q  <= wupcnt_d;
            suscnt_q  <= suscnt_d;
            tskpri_q  <= tskpri_d;
            rdq_add_q <= rdq_add_d;
            tim_arm_q <= tim_arm_d;
            timcnt_q  <= timcnt_d;
            fmode_q   <= fmode_d;
            fptn_q    <= fptn_d;
        end
    end

    always_comb begin
        if (wai_q && sus_q) begin
            tskstat_o = 4'hC;
        end else if (wai_q) begin
            tskstat_o = 4'h4;
        end else if (sus_q) begin
            tskstat_o = 4'h8;
        end else if (my_run) begin
            tskstat_o = 4'h1;
        end else begin
            tskstat_o = 4'h2;
        end
    end

    assign busy_o    = rdq_add_q;
    assign rdq_add_o = rdq_add_q;
    assign rdq_rmv_o = rmv;
    assign tskwait_o = tskwait_q;
    assign wairet_o  = wairet_q;
    assign wupcnt_o  = wupcnt_q;
    assign suscnt_o  = suscnt_q;
    assign tskpri_o  = tskpri_q;

endmodule

// File: tb/tb_jelly_rtos_task_tmo.sv
// Directed bench for jelly_rtos_task_tmo: vector table plus
// hand-written multi-cycle sequences for timed waits.
module tb_jelly_rtos_task_tmo;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cke;
    logic        busy;
    logic [3:0]  tskstat, tskwait;
    logic [1:0]  wairet;
    logic [0:0]  wupcnt, suscnt;
    logic [3:0]  tskpri;
    logic        rdq_add, rdq_rmv;
    logic        rdy_tsk, rel_tsk;
    logic [3:0]  flgptn, run_tskid, op_tskid;
    logic        wup, slp, sus, rsm, dly, relwai, waisem, waiflg, chgpri;
    logic [31:0] tmout;
    logic [3:0]  npri;
    logic        wfmode;
    logic [3:0]  wptn;

    int checks = 0;
    int errors = 0;

    jelly_rtos_task_tmo #(.TSKID(3)) dut (
        .clk(clk), .reset(reset), .cke_i(cke), .busy_o(busy),
        .tskstat_o(tskstat), .tskwait_o(tskwait), .wairet_o(wairet),
        .wupcnt_o(wupcnt), .suscnt_o(suscnt), .tskpri_o(tskpri),
        .rdq_add_o(rdq_add), .rdq_rmv_o(rdq_rmv),
        .rdy_tsk_i(rdy_tsk), .rel_tsk_i(rel_tsk), .flgptn_i(flgptn),
        .run_tskid_i(run_tskid), .op_tskid_i(op_tskid),
        .wup_tsk_i(wup), .slp_tsk_i(slp), .sus_tsk_i(sus),
        .rsm_tsk_i(rsm), .dly_tsk_i(dly), .rel_wai_i(relwai),
        .wai_sem_i(waisem), .wai_flg_i(waiflg), .chg_pri_i(chgpri),
        .op_tmout_i(tmout), .op_tskpri_i(npri),
        .wai_flg_wfmode_i(wfmode), .wai_flg_flgptn_i(wptn)
    );

    always #5 clk = ~clk;

    // op: 0 none 1 wup 2 slp 3 sus 4 rsm 5 dly 6 rel_wai
    //     7 wai_sem 8 wai_flg 9 chg_pri
    typedef struct {
        logic [3:0]  op;
        logic [3:0]  otid;
        logic [3:0]  rtid;
        logic [31:0] tmo;
        logic [3:0]  npri;
        logic [3:0]  flg;
        logic        wfm;
        logic [3:0]  wptn;
        logic        rel;
        logic        rdy;
        logic        rmv;
        logic [3:0]  stat;
        logic [3:0]  wt;
        logic [1:0]  ret;
        logic        add;
        logic [3:0]  pri;
        logic        wupc;
        logic        susc;
    } vec_t;

    vec_t tbl[28];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_ops();
        wup = 0; slp = 0; sus = 0; rsm = 0; dly = 0;
        relwai = 0; waisem = 0; waiflg = 0; chgpri = 0;
        rel_tsk = 0; rdy_tsk = 0;
    endtask

    task automatic set_op(input logic [3:0] op);
        clr_ops();
        case (op)
            4'd1: wup = 1;
            4'd2: slp = 1;
            4'd3: sus = 1;
            4'd4: rsm = 1;
            4'd5: dly = 1;
            4'd6: relwai = 1;
            4'd7: waisem = 1;
            4'd8: waiflg = 1;
            4'd9: chgpri = 1;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr_ops();
    endtask

    task automatic chk_state(input string tag, input logic [3:0] st,
                             input logic [1:0] rt, input logic ad);
        chk({tag, ".stat"}, 32'(tskstat), 32'(st));
        chk({tag, ".ret"}, 32'(wairet), 32'(rt));
        chk({tag, ".add"}, 32'(rdq_add), 32'(ad));
    endtask

    initial begin
        // op otid rtid tmo npri flg wfm wptn rel rdy | rmv stat wt ret add pri wup sus
        tbl[0]  = '{0, 3, 0, 0,    0, 0, 0, 0, 0, 0, 0, 4, 2, 0, 0, 3, 0, 0};
        tbl[1]  = '{1, 3, 0, 0,    0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 3, 0, 0};
        tbl[2]  = '{1, 5, 0, 0,    0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 3, 0, 0};
        tbl[3]  = '{0, 3, 0, 0,    0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 3, 0, 0};
        tbl[4]  = '{1, 3, 0, 0,    0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 3, 1, 0};
        tbl[5]  = '{1, 3, 0, 0,    0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 3, 1, 0};
        tbl[6]  = '{2, 3, 3, ONES, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0};
        tbl[7]  = '{2, 3, 3, ONES, 0, 0, 0, 0, 0, 0, 1, 4, 2, 0, 0, 3, 0, 0};
        tbl[8]  = '{0, 3, 0, 0,    0, 0, 0, 0, 0, 0, 0, 4, 2, 0, 0, 3, 0, 0};
        tbl[9]  = '{6, 3, 0, 0,    0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 1, 3, 0, 0};
        tbl[10] = '{0, 3, 0, 0,    0, 0, 0, 0, 0, 1, 0, 2, 0, 2, 0, 3, 0, 0};
        tbl[11] = '{9, 3, 0, 0,    7, 0, 0, 0, 0, 0, 1, 2, 0, 2, 1, 7, 0, 0};
        tbl[12] = '{9, 3, 0, 0,    5, 0, 0, 0, 0, 1, 1, 2, 0, 2, 1, 5, 0, 0};
        tbl[13] = '{0, 3, 0, 0,    0, 0, 0, 0, 0, 1, 0, 2, 0, 2, 0, 5, 0, 0};
        tbl[14] = '{3, 3, 0, 0,    0, 0, 0, 0, 0, 0, 1, 8, 0, 2, 0, 5, 0, 1};
        tbl[15] = '{3, 3, 0, 0,    0, 0, 0, 0, 0, 0, 0, 8, 0, 2, 0, 5, 0, 1};
        tbl[16] = '{9, 3, 0, 0,    2, 0, 0, 0, 0, 0, 0, 8, 0, 2, 0, 2, 0, 1};
        tbl[17] = '{4, 3, 0, 0,    0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 1, 2, 0, 0};
        tbl[18] = '{0, 3, 0, 0,    0, 0, 0, 0, 0, 1, 0, 2, 0, 2, 0, 2, 0, 0};
        tbl[19] = '{5, 3, 0, 0,    0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0, 2, 0, 0};
        tbl[20] = '{0, 3, 0, 0,    0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 2, 0, 0};
        tbl[21] = '{0, 3, 0, 0,    0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 2, 0, 0};
        tbl[22] = '{8, 3, 3, ONES, 0, 0, 1, 6, 0, 0, 1, 4, 8, 0, 0, 2, 0, 0};
        tbl[23] = '{0, 3, 0, 0,    0, 8, 0, 0, 0, 0, 0, 4, 8, 0, 0, 2, 0, 0};
        tbl[24] = '{0, 3, 0, 0,    0, 4, 0, 0, 0, 0, 0, 2, 0, 0, 1, 2, 0, 0};
        tbl[25] = '{0, 3, 0, 0,    0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 2, 0, 0};
        tbl[26] = '{7, 3, 0, ONES, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 2, 0, 0};
        tbl[27] = '{6, 3, 0, 0,    0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 2, 0, 0};

        reset = 1; cke = 1; clr_ops();
        flgptn = 0; run_tskid = 0; op_tskid = 3;
        tmout = 0; npri = 0; wfmode = 0; wptn = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;

        for (int i = 0; i < 28; i++) begin
            set_op(tbl[i].op);
            op_tskid = tbl[i].otid;
            run_tskid = tbl[i].rtid;
            tmout = tbl[i].tmo;
            npri = tbl[i].npri;
            flgptn = tbl[i].flg;
            wfmode = tbl[i].wfm;
            wptn = tbl[i].wptn;
            rel_tsk = tbl[i].rel;
            rdy_tsk = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d.rmv", i), 32'(rdq_rmv), 32'(tbl[i].rmv));
            tick();
            chk($sformatf("v%0d.stat", i), 32'(tskstat), 32'(tbl[i].stat));
            chk($sformatf("v%0d.wait", i), 32'(tskwait), 32'(tbl[i].wt));
            chk($sformatf("v%0d.ret", i), 32'(wairet), 32'(tbl[i].ret));
            chk($sformatf("v%0d.add", i), 32'(rdq_add), 32'(tbl[i].add));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].add));
            chk($sformatf("v%0d.pri", i), 32'(tskpri), 32'(tbl[i].pri));
            chk($sformatf("v%0d.wup", i), 32'(wupcnt), 32'(tbl[i].wupc));
            chk($sformatf("v%0d.sus", i), 32'(suscnt), 32'(tbl[i].susc));
        end
        op_tskid = 3; run_tskid = 0; flgptn = 0;

        // slp_tsk with timeout 5: released 6 cycles after entry.
        run_tskid = 3; slp = 1; tmout = 5;
        #1;
        chk("slp5.rmv", 32'(rdq_rmv), 32'd1);
        tick();
        run_tskid = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("slp5.hold%0d", k), 32'(tskstat), 32'h4);
        end
        tick();
        chk_state("slp5.tmo", 4'h2, 2'd1, 1'b1);
        rdy_tsk = 1;
        tick();

        // wai_flg AND 0011, forever: partial pattern must not release.
        run_tskid = 3; waiflg = 1; wfmode = 0; wptn = 4'b0011;
        tmout = ONES; flgptn = 4'b0001;
        tick();
        run_tskid = 0;
        chk_state("flg.enter", 4'h4, 2'd0, 1'b0);
        chk("flg.wait", 32'(tskwait), 32'h8);
        repeat (2) tick();
        chk("flg.partial", 32'(tskstat), 32'h4);
        flgptn = 4'b0011;
        tick();
        chk_state("flg.match", 4'h2, 2'd0, 1'b1);
        flgptn = 0; rdy_tsk = 1;
        tick();

        // wai_sem timeout 3 with rel_tsk on the expiry cycle.
        run_tskid = 3; waisem = 1; tmout = 3;
        tick();
        run_tskid = 0;
        repeat (3) tick();
        chk("sem.hold", 32'(tskstat), 32'h4);
        rel_tsk = 1;
        tick();
        chk_state("sem.rel", 4'h2, 2'd0, 1'b1);
        tick();
        chk("sem.addhold", 32'(rdq_add), 32'd1);
        rdy_tsk = 1;
        tick();
        chk("sem.ack", 32'(rdq_add), 32'd0);
        tick();
        chk("sem.single", 32'(rdq_add), 32'd0);

        // Suspend during a timed wait, then timeout, then resume.
        run_tskid = 3; waisem = 1; tmout = 2;
        tick();
        run_tskid = 0;
        sus = 1;
        #1;
        chk("was.rmv", 32'(rdq_rmv), 32'd0);
        tick();
        chk("was.stat", 32'(tskstat), 32'hC);
        tick();
        chk("was.hold", 32'(tskstat), 32'hC);
        tick();
        chk_state("was.tmo", 4'h8, 2'd1, 1'b0);
        chk("was.wait", 32'(tskwait), 32'h0);
        rsm = 1;
        tick();
        chk_state("was.rsm", 4'h2, 2'd1, 1'b1);
        chk("was.suscnt", 32'(suscnt), 32'd0);
        rdy_tsk = 1;
        tick();

        // Clock enable low: op ignored, nothing changes.
        cke = 0; chgpri = 1; npri = 9;
        #1;
        chk("cke.rmv", 32'(rdq_rmv), 32'd0);
        tick();
        chk("cke.pri", 32'(tskpri), 32'h2);
        chk("cke.add", 32'(rdq_add), 32'd0);
        cke = 1;

        // Reset in the middle of a timed delay.
        chgpri = 1; npri = 9;
        tick();
        rdy_tsk = 1; wup = 1;
        tick();
        dly = 1; tmout = 10;
        tick();
        chk("rst.pre", 32'(tskwait), 32'h1);
        reset = 1;
        tick();
        reset = 0;
        chk_state("rst", 4'h4, 2'd0, 1'b0);
        chk("rst.wait", 32'(tskwait), 32'h2);
        chk("rst.pri", 32'(tskpri), 32'h3);
        chk("rst.wup", 32'(wupcnt), 32'd0);
        chk("rst.sus", 32'(suscnt), 32'd0);
        repeat (15) tick();
        chk("rst.disarm", 32'(tskstat), 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
